// File: rtl/disp_addr_pkg.sv
// Shared definitions for the address router: channel state encoding, the
// error read pattern and the per-slave window decode helpers.
package disp_addr_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_RESP = 2'd2
    } ch_state_e;

    localparam int          MAX_ADDR_W = 64;
    localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;

    // Addresses are widened to MAX_ADDR_W so one helper serves any ADDR_W.
    function automatic logic win_hit(input logic [MAX_ADDR_W-1:0] addr,
                                     input logic [MAX_ADDR_W-1:0] base,
                                     input logic [5:0]            win);
        return (addr >> win) == (base >> win);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] win_offset(input logic [MAX_ADDR_W-1:0] addr,
                                                         input logic [5:0]            win);
        return addr & ((64'd1 << win) - 64'd1);
    endfunction

endpackage

// File: rtl/disp_addr_channel.sv
// One request channel of the address router: decodes the requester address to a
// slave window, strobes that slave until it acks or times out, then pulses the ack.
module disp_addr_channel
    import disp_addr_pkg::*;
#(
    parameter int                          NUM_SLAVES = 6,
    parameter int                          ADDR_W     = 32,
    parameter int                          DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*6-1:0]      SLAVE_WIN  = {NUM_SLAVES{6'd12}},
    parameter int                          TIMEOUT    = 255,
    parameter bit                          HAS_RDATA  = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [DATA_W-1:0]            req_data_i,
    input  logic                         req_valid_i,
    output logic                         cpl_ack_o,
    output logic                         cpl_err_o,
    output logic [DATA_W-1:0]            cpl_rdata_o,
    output logic [ADDR_W-1:0]            slv_addr_o,
    output logic [DATA_W-1:0]            slv_data_o,
    output logic [NUM_SLAVES-1:0]        slv_valid_o,
    input  logic [NUM_SLAVES-1:0]        slv_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DATA_W-1:0] ERR_RDATA = HAS_RDATA ? DATA_W'(ERR_DATA) : '0;

    ch_state_e               state_q;
    logic [NUM_SLAVES-1:0]   valid_q;
    logic                    ack_q;
    logic                    err_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       data_q;
    logic [IDX_W-1:0]        idx_q;

    logic                    hit_d;
    logic [IDX_W-1:0]        idx_d;
    logic [5:0]              win_d;
    logic                    sel_ack;
    logic [DATA_W-1:0]       sel_rdata;
    logic                    timeout_hit;

    // Walk from the top slave down so the lowest matching index wins on overlap.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        win_d = 6'd0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (win_hit(MAX_ADDR_W'(req_addr_i),
                        MAX_ADDR_W'(SLAVE_BASE[k*ADDR_W +: ADDR_W]),
                        SLAVE_WIN[k*6 +: 6])) begin
                hit_d = 1'b1;
                idx_d = IDX_W'(k);
                win_d = SLAVE_WIN[k*6 +: 6];
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) sel_ack = slv_ack_i[k];
        end
    end

    generate
        if (HAS_RDATA) begin : g_rmux
            always_comb begin
                sel_rdata = '0;
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (idx_q == IDX_W'(k)) sel_rdata = slv_rdata_i[k*DATA_W +: DATA_W];
                end
            end
        end else begin : g_nomux
            logic unused_rdata;
            assign unused_rdata = ^slv_rdata_i;
            assign sel_rdata    = '0;
        end
    endgenerate

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Request payload only changes on acceptance, so it stays stable until IDLE.
    always_ff @(posedge clk_i) begin
        if (state_q == CH_IDLE && req_valid_i) begin
            addr_q <= ADDR_W'(win_offset(MAX_ADDR_W'(req_addr_i), win_d));
            data_q <= req_data_i;
            idx_q  <= idx_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CH_IDLE;
            valid_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    if (req_valid_i) begin
                        if (hit_d) begin
                            state_q <= CH_WAIT;
                            valid_q <= NUM_SLAVES'(1) << idx_d;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= CH_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= ERR_RDATA;
                        end
                    end
                end
                CH_WAIT: begin
                    if (sel_ack) begin
                        state_q <= CH_RESP;
                        valid_q <= '0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= sel_rdata;
                    end else if (timeout_hit) begin
                        state_q <= CH_RESP;
                        valid_q <= '0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= ERR_RDATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CH_RESP: begin
                    state_q <= CH_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= CH_IDLE;
                    valid_q <= '0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign cpl_ack_o   = ack_q;
    assign cpl_err_o   = err_q;
    assign cpl_rdata_o = rdata_q;
    assign slv_addr_o  = addr_q;
    assign slv_data_o  = data_q;
    assign slv_valid_o = valid_q;

endmodule

// File: rtl/disp_address_router.sv
// Routes one write and one read requester to NUM_SLAVES address windows through
// two independent channels; only the read channel carries slave data back.
module disp_address_router
    import disp_addr_pkg::*;
#(
    parameter int                          NUM_SLAVES = 6,
    parameter int                          ADDR_W     = 32,
    parameter int                          DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h5000, 32'h4000, 32'h3000,
                                                          32'h2000, 32'h1000, 32'h0000},
    parameter logic [NUM_SLAVES*6-1:0]      SLAVE_WIN  = {NUM_SLAVES{6'd12}},
    parameter int                          TIMEOUT    = 255
) (
    input  logic                         iClock,
    input  logic                         iReset,
    input  logic [ADDR_W-1:0]            iCPLWriteAddress,
    input  logic [DATA_W-1:0]            iCPLWriteData,
    input  logic                         iCPLWriteValid,
    output logic                         oCPLWriteAck,
    output logic                         oCPLWriteErr,
    input  logic [ADDR_W-1:0]            iCPLReadAddress,
    input  logic                         iCPLReadValid,
    output logic [DATA_W-1:0]            oCPLReadData,
    output logic                         oCPLReadAck,
    output logic                         oCPLReadErr,
    output logic [ADDR_W-1:0]            oSlvWriteAddress,
    output logic [DATA_W-1:0]            oSlvWriteData,
    output logic [NUM_SLAVES-1:0]        oSlvWriteValid,
    input  logic [NUM_SLAVES-1:0]        iSlvWriteAck,
    output logic [ADDR_W-1:0]            oSlvReadAddress,
    output logic [NUM_SLAVES-1:0]        oSlvReadValid,
    input  logic [NUM_SLAVES*DATA_W-1:0] iSlvReadData,
    input  logic [NUM_SLAVES-1:0]        iSlvReadAck
);

    logic [DATA_W-1:0] unused_wr_rdata;
    logic [DATA_W-1:0] unused_rd_wdata;

    disp_addr_channel #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_WIN  (SLAVE_WIN),
        .TIMEOUT    (TIMEOUT),
        .HAS_RDATA  (1'b0)
    ) u_wr_chan (
        .clk_i       (iClock),
        .rst_ni      (iReset),
        .req_addr_i  (iCPLWriteAddress),
        .req_data_i  (iCPLWriteData),
        .req_valid_i (iCPLWriteValid),
        .cpl_ack_o   (oCPLWriteAck),
        .cpl_err_o   (oCPLWriteErr),
        .cpl_rdata_o (unused_wr_rdata),
        .slv_addr_o  (oSlvWriteAddress),
        .slv_data_o  (oSlvWriteData),
        .slv_valid_o (oSlvWriteValid),
        .slv_ack_i   (iSlvWriteAck),
        .slv_rdata_i ('0)
    );

    disp_addr_channel #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_WIN  (SLAVE_WIN),
        .TIMEOUT    (TIMEOUT),
        .HAS_RDATA  (1'b1)
    ) u_rd_chan (
        .clk_i       (iClock),
        .rst_ni      (iReset),
        .req_addr_i  (iCPLReadAddress),
        .req_data_i  ('0),
        .req_valid_i (iCPLReadValid),
        .cpl_ack_o   (oCPLReadAck),
        .cpl_err_o   (oCPLReadErr),
        .cpl_rdata_o (oCPLReadData),
        .slv_addr_o  (oSlvReadAddress),
        .slv_data_o  (unused_rd_wdata),
        .slv_valid_o (oSlvReadValid),
        .slv_ack_i   (iSlvReadAck),
        .slv_rdata_i (iSlvReadData)
    );

endmodule

// File: tb/tb_disp_address_router.sv
// Directed bench for disp_address_router with default parameters: hit, miss,
// timeout, concurrent channels and asynchronous reset scenarios.
module tb_disp_address_router;

    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              iClock = 1'b0;
    logic              iReset = 1'b0;
    logic [AW-1:0]     iCPLWriteAddress = '0;
    logic [DW-1:0]     iCPLWriteData = '0;
    logic              iCPLWriteValid = 1'b0;
    logic              oCPLWriteAck;
    logic              oCPLWriteErr;
    logic [AW-1:0]     iCPLReadAddress = '0;
    logic              iCPLReadValid = 1'b0;
    logic [DW-1:0]     oCPLReadData;
    logic              oCPLReadAck;
    logic              oCPLReadErr;
    logic [AW-1:0]     oSlvWriteAddress;
    logic [DW-1:0]     oSlvWriteData;
    logic [NS-1:0]     oSlvWriteValid;
    logic [NS-1:0]     iSlvWriteAck = '0;
    logic [AW-1:0]     oSlvReadAddress;
    logic [NS-1:0]     oSlvReadValid;
    logic [NS*DW-1:0]  iSlvReadData = '0;
    logic [NS-1:0]     iSlvReadAck = '0;

    int n_cmp = 0;
    int n_err = 0;

    disp_address_router dut (
        .iClock           (iClock),
        .iReset           (iReset),
        .iCPLWriteAddress (iCPLWriteAddress),
        .iCPLWriteData    (iCPLWriteData),
        .iCPLWriteValid   (iCPLWriteValid),
        .oCPLWriteAck     (oCPLWriteAck),
        .oCPLWriteErr     (oCPLWriteErr),
        .iCPLReadAddress  (iCPLReadAddress),
        .iCPLReadValid    (iCPLReadValid),
        .oCPLReadData     (oCPLReadData),
        .oCPLReadAck      (oCPLReadAck),
        .oCPLReadErr      (oCPLReadErr),
        .oSlvWriteAddress (oSlvWriteAddress),
        .oSlvWriteData    (oSlvWriteData),
        .oSlvWriteValid   (oSlvWriteValid),
        .iSlvWriteAck     (iSlvWriteAck),
        .oSlvReadAddress  (oSlvReadAddress),
        .oSlvReadValid    (oSlvReadValid),
        .iSlvReadData     (iSlvReadData),
        .iSlvReadAck      (iSlvReadAck)
    );

    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_wr_ack",   64'(oCPLWriteAck),   64'd0);
        chk("rst_rd_ack",   64'(oCPLReadAck),    64'd0);
        chk("rst_wr_valid", 64'(oSlvWriteValid), 64'd0);
        chk("rst_rd_valid", 64'(oSlvReadValid),  64'd0);
        chk("rst_rd_data",  64'(oCPLReadData),   64'd0);
        iReset = 1'b1;

        // Write 0x1004 -> slave 1, offset 0x004, acked 3 cycles after strobe
        iCPLWriteAddress = 32'h1004;
        iCPLWriteData    = 32'hA5A5A5A5;
        iCPLWriteValid   = 1'b1;
        tick();
        chk("wr1_valid",  64'(oSlvWriteValid),   64'b000010);
        chk("wr1_offset", 64'(oSlvWriteAddress), 64'h004);
        chk("wr1_data",   64'(oSlvWriteData),    64'hA5A5A5A5);
        chk("wr1_noack",  64'(oCPLWriteAck),     64'd0);
        iSlvWriteAck = 6'b000100;
        tick();
        chk("wr1_foreign_ack_valid", 64'(oSlvWriteValid), 64'b000010);
        chk("wr1_foreign_ack_cpl",   64'(oCPLWriteAck),   64'd0);
        iSlvWriteAck = 6'b000000;
        tick();
        chk("wr1_hold_valid",  64'(oSlvWriteValid),   64'b000010);
        chk("wr1_hold_offset", 64'(oSlvWriteAddress), 64'h004);
        iSlvWriteAck = 6'b000010;
        tick();
        chk("wr1_ack",       64'(oCPLWriteAck),   64'd1);
        chk("wr1_err",       64'(oCPLWriteErr),   64'd0);
        chk("wr1_valid_off", 64'(oSlvWriteValid), 64'd0);
        iSlvWriteAck   = 6'b000000;
        iCPLWriteValid = 1'b0;
        tick();
        chk("wr1_ack_pulse", 64'(oCPLWriteAck), 64'd0);

        // Read 0x3010 -> slave 3 returns 0x12345678
        iCPLReadAddress = 32'h3010;
        iCPLReadValid   = 1'b1;
        tick();
        chk("rd1_valid",     64'(oSlvReadValid),   64'b001000);
        chk("rd1_offset",    64'(oSlvReadAddress), 64'h010);
        chk("rd1_data_wait", 64'(oCPLReadData),    64'd0);
        iSlvReadData[3*DW +: DW] = 32'h12345678;
        iSlvReadData[2*DW +: DW] = 32'hFFFFFFFF;
        iSlvReadAck = 6'b001000;
        tick();
        chk("rd1_ack",  64'(oCPLReadAck),  64'd1);
        chk("rd1_err",  64'(oCPLReadErr),  64'd0);
        chk("rd1_data", 64'(oCPLReadData), 64'h12345678);
        iSlvReadAck   = 6'b000000;
        iCPLReadValid = 1'b0;
        tick();
        chk("rd1_ack_pulse", 64'(oCPLReadAck),  64'd0);
        chk("rd1_data_zero", 64'(oCPLReadData), 64'd0);

        // Unmapped write 0x9000: error ack one cycle after acceptance
        iCPLWriteAddress = 32'h9000;
        iCPLWriteData    = 32'h0BADF00D;
        iCPLWriteValid   = 1'b1;
        tick();
        chk("wr_miss_ack",   64'(oCPLWriteAck),   64'd1);
        chk("wr_miss_err",   64'(oCPLWriteErr),   64'd1);
        chk("wr_miss_valid", 64'(oSlvWriteValid), 64'd0);
        iCPLWriteValid = 1'b0;
        tick();
        chk("wr_miss_pulse", 64'(oCPLWriteAck), 64'd0);

        // Unmapped read just above the top window returns the error pattern
        iCPLReadAddress = 32'h6000;
        iCPLReadValid   = 1'b1;
        tick();
        chk("rd_miss_ack",  64'(oCPLReadAck),  64'd1);
        chk("rd_miss_err",  64'(oCPLReadErr),  64'd1);
        chk("rd_miss_data", 64'(oCPLReadData), 64'hDEADBEEF);
        iCPLReadValid = 1'b0;
        tick();

        // Read 0x2000 with slave 2 silent: strobe for 255 cycles, then timeout
        iCPLReadAddress = 32'h2000;
        iCPLReadValid   = 1'b1;
        tick();
        chk("rd_to_valid_first", 64'(oSlvReadValid), 64'b000100);
        repeat (254) tick();
        chk("rd_to_valid_last", 64'(oSlvReadValid), 64'b000100);
        chk("rd_to_noack",      64'(oCPLReadAck),   64'd0);
        tick();
        chk("rd_to_ack",   64'(oCPLReadAck),   64'd1);
        chk("rd_to_err",   64'(oCPLReadErr),   64'd1);
        chk("rd_to_data",  64'(oCPLReadData),  64'hDEADBEEF);
        chk("rd_to_valid", 64'(oSlvReadValid), 64'd0);
        iCPLReadValid = 1'b0;
        iSlvReadAck   = 6'b000100;
        tick();
        chk("rd_to_late_ack", 64'(oCPLReadAck),   64'd0);
        chk("rd_to_late_vld", 64'(oSlvReadValid), 64'd0);
        iSlvReadAck = 6'b000000;
        tick();

        // Concurrent write 0x4000 and read 0x4008 on slave 4
        iCPLWriteAddress = 32'h4000;
        iCPLWriteData    = 32'h11223344;
        iCPLWriteValid   = 1'b1;
        iCPLReadAddress  = 32'h4008;
        iCPLReadValid    = 1'b1;
        tick();
        chk("cc_wr_valid",  64'(oSlvWriteValid),   64'b010000);
        chk("cc_rd_valid",  64'(oSlvReadValid),    64'b010000);
        chk("cc_wr_offset", 64'(oSlvWriteAddress), 64'h000);
        chk("cc_rd_offset", 64'(oSlvReadAddress),  64'h008);
        iSlvReadData[4*DW +: DW] = 32'hCAFEF00D;
        iSlvReadAck  = 6'b010000;
        iSlvWriteAck = 6'b100000;
        tick();
        chk("cc_rd_ack",      64'(oCPLReadAck),    64'd1);
        chk("cc_rd_data",     64'(oCPLReadData),   64'hCAFEF00D);
        chk("cc_wr_noack",    64'(oCPLWriteAck),   64'd0);
        chk("cc_wr_validkep", 64'(oSlvWriteValid), 64'b010000);
        iSlvReadAck   = 6'b000000;
        iCPLReadValid = 1'b0;
        iSlvWriteAck  = 6'b010000;
        tick();
        chk("cc_wr_ack",    64'(oCPLWriteAck), 64'd1);
        chk("cc_wr_err",    64'(oCPLWriteErr), 64'd0);
        chk("cc_rd_idle",   64'(oCPLReadAck),  64'd0);
        iSlvWriteAck   = 6'b000000;
        iCPLWriteValid = 1'b0;
        tick();
        chk("cc_wr_pulse", 64'(oCPLWriteAck), 64'd0);

        // Asynchronous reset in the middle of WAIT on both channels
        iCPLWriteAddress = 32'h0010;
        iCPLWriteValid   = 1'b1;
        iCPLReadAddress  = 32'h5FFC;
        iCPLReadValid    = 1'b1;
        tick();
        chk("ar_wr_valid",  64'(oSlvWriteValid),  64'b000001);
        chk("ar_rd_valid",  64'(oSlvReadValid),   64'b100000);
        chk("ar_rd_offset", 64'(oSlvReadAddress), 64'hFFC);
        #2;
        iReset         = 1'b0;
        iCPLWriteValid = 1'b0;
        iCPLReadValid  = 1'b0;
        #1;
        chk("ar_async_wr_valid", 64'(oSlvWriteValid), 64'd0);
        chk("ar_async_rd_valid", 64'(oSlvReadValid),  64'd0);
        tick();
        iReset = 1'b1;
        iCPLWriteAddress = 32'h0020;
        iCPLWriteData    = 32'h5A5A0001;
        iCPLWriteValid   = 1'b1;
        tick();
        chk("ar_post_valid",  64'(oSlvWriteValid),   64'b000001);
        chk("ar_post_offset", 64'(oSlvWriteAddress), 64'h020);
        iSlvWriteAck = 6'b000001;
        tick();
        chk("ar_post_ack", 64'(oCPLWriteAck), 64'd1);
        chk("ar_post_err", 64'(oCPLWriteErr), 64'd0);
        iSlvWriteAck   = 6'b000000;
        iCPLWriteValid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
